// File: rtl/vend_controller.sv
`default_nettype none
// ============================================================================
// Module   : vend_controller
// Purpose  : Vending-machine controller. Accumulates coin credit, serves item
//            selections against a loadable price/stock table, pays change one
//            coin per handshake, and drives LEDs and the display value.
// Revision : 1.0 - initial release
// ============================================================================
module vend_controller #(
  parameter int NUM_ITEMS  = 9,
  parameter int IDX_W      = 4,
  parameter int CENT_W     = 10,
  parameter int STOCK_W    = 4,
  parameter int MAX_CREDIT = 500,
  parameter int DISP_HOLD  = 200
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_coin_valid,
  input  logic [2:0]           i_coin_type,
  output logic                 o_coin_reject,
  input  logic                 i_sel_valid,
  input  logic [IDX_W-1:0]     i_sel_idx,
  input  logic                 i_cancel,
  input  logic                 i_cfg_we,
  input  logic [IDX_W-1:0]     i_cfg_idx,
  input  logic [CENT_W-1:0]    i_cfg_price,
  input  logic [STOCK_W-1:0]   i_cfg_stock,
  output logic                 o_vend_valid,
  output logic [IDX_W-1:0]     o_vend_idx,
  output logic                 o_sel_denied,
  output logic                 o_change_valid,
  output logic [1:0]           o_change_coin,
  input  logic                 i_change_ready,
  output logic [CENT_W-1:0]    o_credit,
  output logic [CENT_W-1:0]    o_disp_cents,
  output logic [NUM_ITEMS-1:0] o_avail_led,
  output logic [NUM_ITEMS-1:0] o_oos_led
);

  localparam int                HOLD_W       = $clog2(DISP_HOLD + 1);
  localparam logic [IDX_W:0]    c_num_items  = (IDX_W+1)'(NUM_ITEMS);
  localparam logic [CENT_W:0]   c_max_credit = (CENT_W+1)'(MAX_CREDIT);
  localparam logic [HOLD_W-1:0] c_disp_hold  = HOLD_W'(DISP_HOLD);
  localparam logic [CENT_W-1:0] c_5   = CENT_W'(5);
  localparam logic [CENT_W-1:0] c_10  = CENT_W'(10);
  localparam logic [CENT_W-1:0] c_25  = CENT_W'(25);
  localparam logic [CENT_W-1:0] c_50  = CENT_W'(50);
  localparam logic [CENT_W-1:0] c_100 = CENT_W'(100);
  localparam logic [CENT_W-1:0] c_500 = CENT_W'(500);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_CHANGE = 2'd2
  } state_t;

  state_t               r_state;
  logic [CENT_W-1:0]    r_price [NUM_ITEMS];
  logic [STOCK_W-1:0]   r_stock [NUM_ITEMS];
  logic [CENT_W-1:0]    r_credit;
  logic [CENT_W-1:0]    r_disp;
  logic [HOLD_W-1:0]    r_hold;
  logic                 r_coin_reject;
  logic                 r_vend_valid;
  logic [IDX_W-1:0]     r_vend_idx;
  logic                 r_sel_denied;
  logic                 r_change_valid;
  logic [1:0]           r_change_coin;

  logic [CENT_W-1:0]    w_coin_cents;
  logic                 w_coin_known;
  logic [CENT_W:0]      w_coin_sum;
  logic                 w_coin_ok;
  logic                 w_sel_in_range;
  logic                 w_cfg_in_range;
  logic [CENT_W-1:0]    w_sel_price;
  logic [STOCK_W-1:0]   w_sel_stock;
  logic                 w_sel_ok;
  logic [CENT_W-1:0]    w_after_vend;
  logic [CENT_W-1:0]    w_after_pay;
  logic [CENT_W-1:0]    w_credit_nxt;
  logic                 w_show_price;
  logic [NUM_ITEMS-1:0] w_oos;

  // Greedy change: largest coin not exceeding the amount (0 = nothing payable)
  function automatic logic [1:0] f_change_coin(input logic [CENT_W-1:0] amt);
    if (amt >= c_25)      return 2'd3;
    else if (amt >= c_10) return 2'd2;
    else if (amt >= c_5)  return 2'd1;
    else                  return 2'd0;
  endfunction

  function automatic logic [CENT_W-1:0] f_coin_cents(input logic [1:0] code);
    case (code)
      2'd1:    return c_5;
      2'd2:    return c_10;
      2'd3:    return c_25;
      default: return '0;
    endcase
  endfunction

  // Decode inserted coin/bill value
  always_comb begin
    w_coin_known = 1'b1;
    w_coin_cents = '0;
    case (i_coin_type)
      3'd0:    w_coin_cents = c_5;
      3'd1:    w_coin_cents = c_10;
      3'd2:    w_coin_cents = c_25;
      3'd3:    w_coin_cents = c_50;
      3'd4:    w_coin_cents = c_100;
      3'd5:    w_coin_cents = c_500;
      default: w_coin_known = 1'b0;
    endcase
  end

  // Sum carries one extra bit so an overflowing insert is caught, not wrapped
  assign w_coin_sum     = {1'b0, r_credit} + {1'b0, w_coin_cents};
  assign w_coin_ok      = i_coin_valid & ~i_cancel & ~i_sel_valid &
                          (r_state != ST_CHANGE) & w_coin_known &
                          (w_coin_sum <= c_max_credit);
  assign w_sel_in_range = ({1'b0, i_sel_idx} < c_num_items);
  assign w_cfg_in_range = ({1'b0, i_cfg_idx} < c_num_items);
  assign w_sel_price    = w_sel_in_range ? r_price[i_sel_idx] : '0;
  assign w_sel_stock    = w_sel_in_range ? r_stock[i_sel_idx] : '0;
  assign w_sel_ok       = w_sel_in_range && (w_sel_price != '0) &&
                          (w_sel_stock != '0) && (r_credit >= w_sel_price);
  assign w_after_vend   = r_credit - w_sel_price;
  assign w_after_pay    = r_credit - f_coin_cents(r_change_coin);

  // Next credit value and whether a price should be put on the display
  always_comb begin
    w_credit_nxt = r_credit;
    w_show_price = 1'b0;
    case (r_state)
      ST_IDLE, ST_CREDIT: begin
        if (!i_cancel && i_sel_valid) begin
          if ((r_state == ST_CREDIT) && w_sel_ok) w_credit_nxt = w_after_vend;
          else                                    w_show_price = 1'b1;
        end else if (w_coin_ok) begin
          w_credit_nxt = w_coin_sum[CENT_W-1:0];
        end
      end
      ST_CHANGE: begin
        // An unpayable remainder (below the smallest coin) is forfeited
        if (!r_change_valid)
          w_credit_nxt = '0;
        else if (i_change_ready)
          w_credit_nxt = (f_change_coin(w_after_pay) == 2'd0) ? '0 : w_after_pay;
      end
      default: w_credit_nxt = '0;
    endcase
  end

  // Main FSM, price/stock table, display hold and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_disp         <= '0;
      r_hold         <= '0;
      r_coin_reject  <= 1'b0;
      r_vend_valid   <= 1'b0;
      r_vend_idx     <= '0;
      r_sel_denied   <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_coin  <= 2'd0;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        r_price[i] <= '0;
        r_stock[i] <= '0;
      end
    end else begin
      r_coin_reject <= i_coin_valid & ~w_coin_ok;
      r_vend_valid  <= 1'b0;
      r_sel_denied  <= 1'b0;
      r_credit      <= w_credit_nxt;

      // A price stays visible for DISP_HOLD cycles unless credit moves
      if (w_show_price) begin
        r_disp <= w_sel_price;
        r_hold <= c_disp_hold;
      end else if ((r_hold > HOLD_W'(1)) && (w_credit_nxt == r_credit)) begin
        r_hold <= r_hold - HOLD_W'(1);
      end else begin
        r_hold <= '0;
        r_disp <= w_credit_nxt;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_coin_ok) r_state <= ST_CREDIT;
          if (i_cfg_we && w_cfg_in_range) begin
            r_price[i_cfg_idx] <= i_cfg_price;
            r_stock[i_cfg_idx] <= i_cfg_stock;
          end
        end
        ST_CREDIT: begin
          if (i_cancel) begin
            r_state        <= ST_CHANGE;
            r_change_valid <= (f_change_coin(r_credit) != 2'd0);
            r_change_coin  <= f_change_coin(r_credit);
          end else if (i_sel_valid) begin
            if (w_sel_ok) begin
              r_vend_valid         <= 1'b1;
              r_vend_idx           <= i_sel_idx;
              r_stock[i_sel_idx]   <= w_sel_stock - STOCK_W'(1);
              if (w_credit_nxt == '0) begin
                r_state <= ST_IDLE;
              end else begin
                r_state        <= ST_CHANGE;
                r_change_valid <= (f_change_coin(w_credit_nxt) != 2'd0);
                r_change_coin  <= f_change_coin(w_credit_nxt);
              end
            end else begin
              r_sel_denied <= 1'b1;
            end
          end
        end
        ST_CHANGE: begin
          if (!r_change_valid) begin
            r_state <= ST_IDLE;
          end else if (i_change_ready) begin
            if (w_credit_nxt == '0) begin
              r_state        <= ST_IDLE;
              r_change_valid <= 1'b0;
              r_change_coin  <= 2'd0;
            end else begin
              r_change_coin <= f_change_coin(w_credit_nxt);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Per-item LEDs straight from the registered table and credit
  generate
    for (genvar g = 0; g < NUM_ITEMS; g++) begin : g_led
      assign w_oos[g]       = (r_price[g] == '0) || (r_stock[g] == '0);
      assign o_avail_led[g] = ~w_oos[g] && (r_credit >= r_price[g]);
    end
  endgenerate

  assign o_oos_led      = w_oos;
  assign o_coin_reject  = r_coin_reject;
  assign o_vend_valid   = r_vend_valid;
  assign o_vend_idx     = r_vend_idx;
  assign o_sel_denied   = r_sel_denied;
  assign o_change_valid = r_change_valid;
  assign o_change_coin  = r_change_coin;
  assign o_credit       = r_credit;
  assign o_disp_cents   = r_disp;

endmodule
`default_nettype wire
